johnson_gen: RTL and testbench

Parametrised multi-mode sequence counter; the next generation of the team's Johnson counter, dropped into the same Tiny Tapeout user-project slot with the standard `ui_in`/`uo_out`/`uio_*` pin set. It adds width and prescale parameters, four sequence modes (Johnson, one-hot ring, binary, Gray), up/down direction, and a run-time prescaler. A status byte on the bidirectional pins exposes step position, mode, tick and wrap.

---
 rtl/johnson_gen_pkg.sv | 35 +++
 rtl/johnson_gen_presc.sv | 43 ++++
 rtl/johnson_gen.sv | 124 ++++++++++++
 tb/tb_johnson_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/johnson_gen_pkg.sv
// Shared mode encodings, status-byte layout and per-mode sequence helpers.
package johnson_gen_pkg;

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_BIN     = 2'b10;
  localparam logic [1:0] MODE_GRAY    = 2'b11;

  // Bit positions inside the status byte on uio_out.
  localparam int ST_WRAP    = 7;
  localparam int ST_TICK    = 6;
  localparam int ST_MODE_HI = 5;
  localparam int ST_MODE_LO = 4;
  localparam int ST_POS_HI  = 3;

  // Starting value loaded into the state register when a mode is entered.
  function automatic logic [7:0] seed_of(input logic [1:0] mode, input int unsigned width);
    logic [7:0] s;
    s = 8'h00;
    if (mode == MODE_RING && width != 0) s[0] = 1'b1;
    return s;
  endfunction

  // Number of steps before the sequence of a mode repeats (up to 256).
  function automatic logic [8:0] period_of(input logic [1:0] mode, input int unsigned width);
    logic [8:0] p;
    case (mode)
      MODE_JOHNSON: p = 9'(width << 1);
      MODE_RING:    p = 9'(width);
      default:      p = 9'(32'd1 << width);
    endcase
    return p;
  endfunction

endpackage

// File: rtl/johnson_gen_presc.sv
// Free-running prescaler: emits a step request every 2^sel active cycles.
module johnson_gen_presc
  import johnson_gen_pkg::*;
#(
  parameter int PRESC_BITS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       clear,
  input  logic [3:0] sel,
  output logic       tick
);

  localparam logic [PRESC_BITS-1:0] PRESC_ONE = PRESC_BITS'(1);

  logic [PRESC_BITS-1:0] presc_q;
  logic [PRESC_BITS-1:0] presc_d;
  logic [PRESC_BITS-1:0] mask;

  // Low sel bits of the mask are set; bits beyond PRESC_BITS do not exist,
  // which clamps oversized selects to the full counter width.
  for (genvar gi = 0; gi < PRESC_BITS; gi++) begin : g_mask
    assign mask[gi] = (32'(gi) < 32'(sel));
  end

  // Tick looks at the value before this cycle's increment.
  assign tick = active & ((presc_q & mask) == mask);

  // Counter advances only on active cycles, so a pause resumes in phase.
  always_comb begin
    presc_d = presc_q;
    if (clear)       presc_d = '0;
    else if (active) presc_d = presc_q + PRESC_ONE;
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

endmodule

// File: rtl/johnson_gen.sv
// Multi-mode sequence counter (Johnson / ring / binary / Gray) with
// up/down stepping, run-time prescaler and a status byte.
module johnson_gen
  import johnson_gen_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESC_BITS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Step index wide enough for the longest period (2^WIDTH), at least 4 bits.
  localparam int POS_W = (WIDTH < 4) ? 4 : WIDTH;
  localparam logic [WIDTH-1:0] STATE_ONE = WIDTH'(1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  logic [WIDTH-1:0] state_q, state_d, state_step;
  logic [1:0]       mode_q, mode_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_last;
  logic             wrap_q, wrap_d;
  logic             tick_q, tick_d;

  logic             run, dir, active, tick, mode_sw;
  logic [1:0]       mode_req;
  logic [8:0]       period;
  logic [WIDTH-1:0] disp;
  logic [7:0]       status;
  logic             unused_ok;

  assign run      = ui_in[0];
  assign dir      = ui_in[1];
  assign mode_req = ui_in[3:2];
  assign active   = ena & run;
  assign mode_sw  = ena & (mode_req != mode_q);
  assign period   = period_of(mode_q, WIDTH);
  assign pos_last = POS_W'(period - 9'd1);
  assign unused_ok = ^uio_in;

  johnson_gen_presc #(
    .PRESC_BITS (PRESC_BITS)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (active),
    .clear  (mode_sw),
    .sel    (ui_in[7:4]),
    .tick   (tick)
  );

  // One step of the current mode's sequence in the requested direction.
  always_comb begin
    state_step = state_q;
    case (mode_q)
      MODE_JOHNSON: state_step = dir ? {~state_q[0], state_q[WIDTH-1:1]}
                                     : {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
      MODE_RING:    state_step = dir ? {state_q[0], state_q[WIDTH-1:1]}
                                     : {state_q[WIDTH-2:0], state_q[WIDTH-1]};
      default:      state_step = dir ? (state_q - STATE_ONE) : (state_q + STATE_ONE);
    endcase
  end

  // Next-state: a mode switch reloads everything and outranks a tick.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    tick_d  = 1'b0;
    if (mode_sw) begin
      mode_d  = mode_req;
      state_d = WIDTH'(seed_of(mode_req, WIDTH));
      pos_d   = '0;
    end else if (tick) begin
      tick_d  = 1'b1;
      state_d = state_step;
      if (dir) begin
        wrap_d = (pos_q == '0);
        pos_d  = (pos_q == '0) ? pos_last : (pos_q - POS_ONE);
      end else begin
        wrap_d = (pos_q == pos_last);
        pos_d  = (pos_q == pos_last) ? '0 : (pos_q + POS_ONE);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      mode_q  <= MODE_JOHNSON;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
      tick_q  <= tick_d;
    end
  end

  // Display and status are decoded from registers only.
  always_comb begin
    disp = (mode_q == MODE_GRAY) ? (state_q ^ (state_q >> 1)) : state_q;
    status = 8'h00;
    status[ST_WRAP]                = wrap_q;
    status[ST_TICK]                = tick_q;
    status[ST_MODE_HI:ST_MODE_LO]  = mode_q;
    status[ST_POS_HI:0]            = pos_q[3:0];
  end

  assign uo_out  = 8'(disp);
  assign uio_out = status;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_johnson_gen.sv
// Randomised scoreboard bench for johnson_gen (WIDTH=8). The reference model
// tracks only mode, step index and active-cycle count; the displayed value is
// derived arithmetically from the step index.
module tb_johnson_gen;

  localparam int W  = 8;
  localparam int PB = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  johnson_gen #(.WIDTH(W), .PRESC_BITS(PB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [23:0] exp_q[$];

  // Reference model state
  int m_mode = 0, m_pos = 0, m_cnt = 0;
  bit m_wrap = 0, m_tick = 0;

  function automatic int period(input int md);
    if (md == 0) return 2 * W;
    if (md == 1) return W;
    return 1 << W;
  endfunction

  // Value shown for step index k of a mode that started from its seed.
  function automatic int shown(input int md, input int k);
    if (md == 0) begin
      if (k <= W) return (1 << k) - 1;
      return ((1 << W) - 1) & ~((1 << (k - W)) - 1);
    end
    if (md == 1) return 1 << k;
    if (md == 2) return k;
    return k ^ (k >> 1);
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [7:0] u);
    int sel, mask, per;
    bit act, t;
    if (!r) begin
      m_mode = 0; m_pos = 0; m_cnt = 0; m_wrap = 0; m_tick = 0;
    end else if (e && int'(u[3:2]) != m_mode) begin
      m_mode = int'(u[3:2]); m_pos = 0; m_cnt = 0; m_wrap = 0; m_tick = 0;
    end else begin
      sel  = int'(u[7:4]);
      if (sel > PB) sel = PB;
      mask = (1 << sel) - 1;
      act  = e && u[0];
      t    = act && ((m_cnt & mask) == mask);
      if (act) m_cnt = (m_cnt + 1) % (1 << PB);
      m_tick = t;
      m_wrap = 0;
      if (t) begin
        per = period(m_mode);
        if (u[1]) begin
          m_wrap = (m_pos == 0);
          m_pos  = (m_pos + per - 1) % per;
        end else begin
          m_wrap = (m_pos == per - 1);
          m_pos  = (m_pos + 1) % per;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic drive(input logic r, input logic e, input logic [7:0] u);
    logic [7:0] x_uo, x_uio;
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = u;
    uio_in = 8'($urandom);
    model_edge(r, e, u);
    x_uo  = 8'(shown(m_mode, m_pos));
    x_uio = {m_wrap, m_tick, 2'(m_mode), 4'(m_pos)};
    exp_q.push_back({x_uo, x_uio, 8'hFF});
  endtask

  // Monitor: pops one expectation per clock and compares away from the edge.
  initial begin
    logic [23:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        cyc++;
        $display("[TB] cyc=%0d rst_n=%b ena=%b ui=%h uo=%h uio=%h oe=%h", cyc, rst_n, ena, ui_in,
                 uo_out, uio_out, uio_oe);
        tests++;
        if (uo_out !== x[23:16]) begin
          fails++;
          $display("FAIL uo_out cyc=%0d got=%h exp=%h", cyc, uo_out, x[23:16]);
        end
        tests++;
        if (uio_out !== x[15:8]) begin
          fails++;
          $display("FAIL uio_out cyc=%0d got=%h exp=%h", cyc, uio_out, x[15:8]);
        end
        tests++;
        if (uio_oe !== x[7:0]) begin
          fails++;
          $display("FAIL uio_oe cyc=%0d got=%h exp=%h", cyc, uio_oe, x[7:0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] u;
    logic       e, r;
    // Reset, then Johnson up through a full period plus a little
    repeat (2) drive(1'b0, 1'b1, 8'h01);
    repeat (20) drive(1'b1, 1'b1, 8'h01);
    // Johnson down from reset, then flip direction
    drive(1'b0, 1'b1, 8'h03);
    repeat (6) drive(1'b1, 1'b1, 8'h03);
    repeat (6) drive(1'b1, 1'b1, 8'h01);
    // Ring mode switch and full ring period
    repeat (12) drive(1'b1, 1'b1, 8'h05);
    // Gray, then binary
    repeat (10) drive(1'b1, 1'b1, 8'h0D);
    repeat (4) drive(1'b1, 1'b1, 8'h09);
    // Prescaler sel=2 with an ena drop
    repeat (12) drive(1'b1, 1'b1, 8'h21);
    repeat (3) drive(1'b1, 1'b0, 8'h21);
    repeat (10) drive(1'b1, 1'b1, 8'h21);
    // Reset mid-run at Johnson 3F
    drive(1'b0, 1'b1, 8'h01);
    repeat (6) drive(1'b1, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h01);
    repeat (5) drive(1'b1, 1'b1, 8'h01);
    // Randomised operation
    u = 8'h01;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        u[0]   = ($urandom_range(0, 7) != 0);
        u[1]   = 1'($urandom_range(0, 1));
        u[3:2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) u[7:4] = 4'($urandom_range(4, 15));
        else                            u[7:4] = 4'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 9) == 0) u[1] = ~u[1];
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 99) != 0);
      drive(r, e, u);
    end
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
